// File: rtl/mul_iter_ctrl.sv
// Sequencing controller for the iterative shift-add multiplier in EX.
// Issues load/step/negate strobes and stalls the front of the pipe until the product is ready.
module mul_iter_ctrl #(
    parameter  int XLEN            = 32,
    parameter  int STEPS_PER_CYCLE = 1,
    localparam int N               = XLEN / STEPS_PER_CYCLE,
    localparam int CNT_W           = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_req,
    input  logic [2:0]       funct3,
    input  logic             rs1_sign,
    input  logic             rs2_sign,
    input  logic             flush,
    output logic             stall_o,
    output logic             busy,
    output logic             dp_load,
    output logic             dp_abs1,
    output logic             dp_abs2,
    output logic             dp_step,
    output logic             dp_neg,
    output logic             dp_sel_hi,
    output logic             result_valid,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] step_cnt_reg, step_cnt_next;
    logic             neg_pend_reg, neg_pend_next;
    logic             sel_hi_reg, sel_hi_next;
    logic             accept;

    // Gated by rst so the load strobe cannot fire while reset is held.
    assign accept = (state_reg == IDLE) & mul_req & ~funct3[2] & ~flush & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            step_cnt_reg <= '0;
            neg_pend_reg <= 1'b0;
            sel_hi_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            step_cnt_reg <= step_cnt_next;
            neg_pend_reg <= neg_pend_next;
            sel_hi_reg   <= sel_hi_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg;
        neg_pend_next = neg_pend_reg;
        sel_hi_next   = sel_hi_reg;
        stall_o       = 1'b0;
        dp_load       = 1'b0;
        dp_abs1       = 1'b0;
        dp_abs2       = 1'b0;
        dp_step       = 1'b0;
        dp_neg        = 1'b0;
        dp_sel_hi     = 1'b0;
        result_valid  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dp_load       = 1'b1;
                    stall_o       = 1'b1;
                    // MULH negates both operands; MULHSU only rs1; MUL/MULHU never.
                    dp_abs1       = rs1_sign & ((funct3 == 3'b001) | (funct3 == 3'b010));
                    dp_abs2       = rs2_sign & (funct3 == 3'b001);
                    neg_pend_next = dp_abs1 ^ dp_abs2;
                    sel_hi_next   = (funct3 != 3'b000);
                    step_cnt_next = '0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                dp_step = 1'b1;
                stall_o = 1'b1;
                if (flush) begin
                    step_cnt_next = '0;
                    state_next    = IDLE;
                end else if (step_cnt_reg == LAST_STEP) begin
                    step_cnt_next = '0;
                    state_next    = neg_pend_reg ? FIX : DONE;
                end else begin
                    step_cnt_next = step_cnt_reg + 1'b1;
                end
            end
            FIX: begin
                dp_neg     = 1'b1;
                stall_o    = 1'b1;
                state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                // Flush is ignored here: the result commits as the pipe advances.
                result_valid = 1'b1;
                dp_sel_hi    = sel_hi_reg;
                state_next   = IDLE;
            end
            default: begin
                state_next    = IDLE;
                step_cnt_next = '0;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign step_cnt = step_cnt_reg;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Bench for mul_iter_ctrl: table of multiply kinds plus flush, back-to-back, reset
// and a two-bits-per-step build; results are matched against a queue of expected completions.
module tb_mul_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mul_req = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic       rs1_sign = 1'b0;
    logic       rs2_sign = 1'b0;
    logic       flush = 1'b0;
    logic       stall_o, busy, dp_load, dp_abs1, dp_abs2, dp_step, dp_neg, dp_sel_hi, result_valid;
    logic [4:0] step_cnt;

    logic       m2_req = 1'b0;
    logic [2:0] m2_f3 = 3'b000;
    logic       m2_stall, m2_busy, m2_load, m2_abs1, m2_abs2, m2_step, m2_neg, m2_sel_hi, m2_valid;
    logic [3:0] m2_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lat;
        bit sel;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string      name;
        logic [2:0] f3;
        bit         s1, s2, a1, a2, fix, sel;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    mul_iter_ctrl #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .mul_req(mul_req), .funct3(funct3),
        .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .flush(flush),
        .stall_o(stall_o), .busy(busy), .dp_load(dp_load), .dp_abs1(dp_abs1),
        .dp_abs2(dp_abs2), .dp_step(dp_step), .dp_neg(dp_neg), .dp_sel_hi(dp_sel_hi),
        .result_valid(result_valid), .step_cnt(step_cnt)
    );

    mul_iter_ctrl #(.XLEN(32), .STEPS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .mul_req(m2_req), .funct3(m2_f3),
        .rs1_sign(1'b1), .rs2_sign(1'b1), .flush(1'b0),
        .stall_o(m2_stall), .busy(m2_busy), .dp_load(m2_load), .dp_abs1(m2_abs1),
        .dp_abs2(m2_abs2), .dp_step(m2_step), .dp_neg(m2_neg), .dp_sel_hi(m2_sel_hi),
        .result_valid(m2_valid), .step_cnt(m2_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({stall_o, busy, dp_load, dp_abs1, dp_abs2, dp_step, dp_neg,
                     dp_sel_hi, result_valid, step_cnt});
    endfunction

    // One multiply: accept at cycle 0, then observe until well past the expected result.
    task automatic do_mul(input string name, input logic [2:0] f3, input bit s1, input bit s2,
                          input bit ea1, input bit ea2, input bit efix, input bit esel,
                          input int flush_cyc);
        int   lat;
        bit   kill;
        int   steps, negs, stalls, excl, stray, res_seen;
        exp_t e;
        lat   = efix ? 34 : 33;
        kill  = (flush_cyc >= 1) && (flush_cyc < lat);
        steps = 0; negs = 0; stalls = 0; excl = 0; stray = 0; res_seen = 0;

        @(negedge clk);
        mul_req = 1'b1; funct3 = f3; rs1_sign = s1; rs2_sign = s2; flush = 1'b0;
        #1;
        chk({name, " load"}, int'(dp_load), 1);
        chk({name, " abs1"}, int'(dp_abs1), int'(ea1));
        chk({name, " abs2"}, int'(ea2 ? dp_abs2 : dp_abs2), int'(ea2));
        e.lat = lat; e.sel = esel;
        sb.push_back(e);
        stalls += int'(stall_o);

        for (int cyc = 1; cyc <= lat + 2; cyc++) begin
            @(negedge clk);
            mul_req  = 1'b0;
            funct3   = 3'($urandom_range(7, 0));
            rs1_sign = 1'($urandom_range(1, 0));
            rs2_sign = 1'($urandom_range(1, 0));
            flush    = (cyc == flush_cyc);
            #1;
            if (kill && cyc == flush_cyc) begin
                void'(sb.pop_back());
                chk({name, " stall at flush"}, int'(stall_o), 1);
                if (cyc <= 32) chk({name, " cnt at flush"}, int'(step_cnt), cyc - 1);
            end
            if (kill && cyc == flush_cyc + 1) begin
                chk({name, " busy after flush"}, int'(busy), 0);
                chk({name, " stall after flush"}, int'(stall_o), 0);
                chk({name, " cnt after flush"}, int'(step_cnt), 0);
            end
            stalls += int'(stall_o);
            steps  += int'(dp_step);
            negs   += int'(dp_neg);
            if (int'(dp_load) + int'(dp_step) + int'(dp_neg) + int'(result_valid) > 1) excl++;
            if ((dp_sel_hi && !result_valid) || dp_load) stray++;
            if (result_valid) begin
                res_seen++;
                if (sb.size() == 0) begin
                    chk({name, " unexpected result"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({name, " result cycle"}, cyc, e.lat);
                    chk({name, " sel_hi"}, int'(dp_sel_hi), int'(e.sel));
                end
            end
        end
        flush = 1'b0;
        chk({name, " strobe overlap"}, excl, 0);
        chk({name, " stray load/sel"}, stray, 0);
        chk({name, " idle at end"}, int'(busy), 0);
        if (kill) begin
            chk({name, " killed result"}, res_seen, 0);
        end else begin
            chk({name, " step count"}, steps, 32);
            chk({name, " neg count"}, negs, int'(efix));
            chk({name, " stall cycles"}, stalls, lat);
        end
        $display("op %s f3=%b s1=%0d s2=%0d flush_cyc=%0d steps=%0d negs=%0d results=%0d",
                 name, f3, s1, s2, flush_cyc, steps, negs, res_seen);
    endtask

    initial begin
        vecs[0] = '{"MULHU_11",  3'b011, 1, 1, 0, 0, 0, 1};
        vecs[1] = '{"MULH_10",   3'b001, 1, 0, 1, 0, 1, 1};
        vecs[2] = '{"MULH_11",   3'b001, 1, 1, 1, 1, 0, 1};
        vecs[3] = '{"MUL_11",    3'b000, 1, 1, 0, 0, 0, 0};
        vecs[4] = '{"MULHSU_11", 3'b010, 1, 1, 1, 0, 1, 1};
        vecs[5] = '{"MULHSU_01", 3'b010, 0, 1, 0, 0, 0, 1};
        vecs[6] = '{"MULH_01",   3'b001, 0, 1, 0, 1, 1, 1};

        // Held in reset with a request pending: everything quiet.
        mul_req = 1'b1; funct3 = 3'b001; rs1_sign = 1'b1; rs2_sign = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset outputs", all_outs(), 0);
        chk("reset dut2 busy", int'(m2_busy), 0);
        $display("reset outs=%0d", all_outs());
        @(negedge clk);
        mul_req = 1'b0; rst = 1'b1;
        #1;
        chk("post-reset idle", all_outs(), 0);

        foreach (vecs[i])
            do_mul(vecs[i].name, vecs[i].f3, vecs[i].s1, vecs[i].s2,
                   vecs[i].a1, vecs[i].a2, vecs[i].fix, vecs[i].sel, -1);

        // Flush in RUN at step 10, then a fresh accept.
        do_mul("MUL_flush_run", 3'b000, 1, 1, 0, 0, 0, 0, 11);
        do_mul("MULHU_after_flush", 3'b011, 0, 1, 0, 0, 0, 1, -1);
        // Flush in FIX kills; flush in DONE does not.
        do_mul("MULH_flush_fix", 3'b001, 1, 0, 1, 0, 1, 1, 33);
        do_mul("MULH_flush_done", 3'b001, 1, 0, 1, 0, 1, 1, 34);

        // Flush together with a request in IDLE: no accept.
        @(negedge clk);
        mul_req = 1'b1; funct3 = 3'b001; flush = 1'b1;
        #1;
        chk("flush+req load", int'(dp_load), 0);
        chk("flush+req stall", int'(stall_o), 0);
        @(negedge clk);
        mul_req = 1'b0; flush = 1'b0;
        #1;
        chk("flush+req idle", int'(busy), 0);
        $display("flush in idle busy=%0d", busy);

        // funct3 1xx: never accepted.
        begin
            int bad = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                mul_req = 1'b1; funct3 = 3'($urandom_range(7, 4));
                #1;
                if (all_outs() != 0) bad++;
            end
            mul_req = 1'b0;
            chk("div ignored", bad, 0);
            $display("div 10 cycles nonzero_cycles=%0d", bad);
        end

        // Back-to-back MULHSU (with FIX) then MUL, then a reset mid-RUN.
        begin
            int res_cyc = -1;
            @(negedge clk);
            mul_req = 1'b1; funct3 = 3'b010; rs1_sign = 1'b1; rs2_sign = 1'b0;
            #1;
            chk("b2b load1", int'(dp_load), 1);
            chk("b2b abs1", int'(dp_abs1), 1);
            for (int cyc = 1; cyc <= 33; cyc++) begin
                @(negedge clk);
                #1;
                if (cyc == 33) chk("b2b neg", int'(dp_neg), 1);
            end
            @(negedge clk);
            funct3 = 3'b000; rs1_sign = 1'b1; rs2_sign = 1'b1;
            #1;
            chk("b2b result 34", int'(result_valid), 1);
            chk("b2b sel_hi", int'(dp_sel_hi), 1);
            chk("b2b no retrigger", int'(dp_load), 0);
            @(negedge clk);
            #1;
            chk("b2b load2", int'(dp_load), 1);
            chk("b2b load2 abs", int'({dp_abs1, dp_abs2}), 0);
            for (int cyc = 36; cyc <= 40; cyc++) begin
                @(negedge clk);
                #1;
                if (result_valid) res_cyc = cyc;
            end
            chk("b2b cnt before reset", int'(step_cnt), 4);
            chk("b2b no early result", res_cyc, -1);
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("mid-op reset outputs", all_outs(), 0);
            $display("b2b reset outs=%0d", all_outs());
            @(negedge clk);
            mul_req = 1'b0; rst = 1'b1;
            #1;
            chk("after reset idle", all_outs(), 0);
        end

        // Two bits per step: 16 RUN cycles, result at 17.
        begin
            int steps = 0;
            int res_cyc = -1;
            @(negedge clk);
            m2_req = 1'b1; m2_f3 = 3'b011;
            #1;
            chk("s2 load", int'(m2_load), 1);
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(negedge clk);
                m2_req = 1'b0;
                #1;
                steps += int'(m2_step);
                if (m2_valid) begin
                    res_cyc = cyc;
                    chk("s2 sel_hi", int'(m2_sel_hi), 1);
                end
            end
            chk("s2 steps", steps, 16);
            chk("s2 result cycle", res_cyc, 17);
            $display("steps2 MULHU steps=%0d result_cycle=%0d", steps, res_cyc);
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
